checkdigit_engine: RTL

Parametrised serial check-digit unit. It accepts one decimal digit per handshake, accumulates a Luhn (mod-10, alternate-doubling) sum, and, once the frame is complete, emits either the generated check digit or a pass/fail verdict. It sits between the digit-entry front end and the result/display stage, and supersedes the fixed 15-digit generator.

---
 rtl/checkdigit_pkg.sv | 26 ++
 rtl/checkdigit_mod10_acc.sv | 39 +++
 rtl/checkdigit_engine.sv | 127 ++++++++++++
 3 files changed

// File: rtl/checkdigit_pkg.sv
// Shared types and helpers for the Luhn check-digit engine.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: FSM state enum, mode constants, Luhn doubling helper.
package checkdigit_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } cd_state_e;

  localparam logic CD_GEN = 1'b0;
  localparam logic CD_VER = 1'b1;

  // Doubled Luhn contribution of a decimal digit: 2d, folded to 2d-9 above 9.
  // Only meaningful for d <= 9; callers mask out invalid digits.
  function automatic logic [3:0] luhn_double(input logic [3:0] d);
    logic [4:0] t;
    t = {d, 1'b0};
    if (t > 5'd9) t = t - 5'd9;
    return t[3:0];
  endfunction

endpackage

// File: rtl/checkdigit_mod10_acc.sv
// Four-bit running sum modulo 10 with synchronous clear and add enable.
// Latency: acc_next is combinational; the stored sum updates on the next edge.
// Backpressure: none; the caller gates add_en with its own handshake.
//
// Ports: clk, rst (async, active-high); clear restarts the sum from 0 and may
// coincide with add_en (the addend then becomes the new sum); add is 0..9;
// acc_next is the value the register takes at the coming edge.
module checkdigit_mod10_acc (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       add_en,
  input  logic [3:0] add,
  output logic [3:0] acc_next
);

  logic [3:0] acc;
  logic [3:0] base;
  logic [4:0] sum;

  always_comb begin
    base = clear ? 4'd0 : acc;
    sum  = {1'b0, base} + {1'b0, add};
    if (!add_en)
      acc_next = base;
    else if (sum >= 5'd10)
      acc_next = 4'(sum - 5'd10);
    else
      acc_next = sum[3:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      acc <= 4'd0;
    else
      acc <= acc_next;
  end

endmodule

// File: rtl/checkdigit_engine.sv
// Serial Luhn unit: one digit per handshake, emits a check digit or pass/fail.
// Latency: result strobe one cycle after the frame's last accepted digit.
// Backpressure: in_ready drops for the single DONE cycle; the source holds.
//
// Ports: clk, rst (async, active-high); in_num/in_valid/in_mode/in_ready digit
// input (mode sampled on a frame's first digit); out_valid one-cycle strobe with
// out (generated digit), out_pass (verify verdict), out_err (digit > 9 seen).
module checkdigit_engine
  import checkdigit_pkg::*;
#(
  parameter int DIGITS = 15,
  parameter int CNT_W  = $clog2(DIGITS + 2)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] in_num,
  input  logic       in_valid,
  input  logic       in_mode,
  output logic       in_ready,
  output logic       out_valid,
  output logic [3:0] out,
  output logic       out_pass,
  output logic       out_err
);

  localparam logic [CNT_W-1:0] LEN_GEN = CNT_W'(DIGITS);
  localparam logic [CNT_W-1:0] LEN_VER = CNT_W'(DIGITS + 1);
  // Index i is doubled when (DIGITS-1-i) is even, i.e. when i has the same
  // parity as DIGITS-1.
  localparam logic DBL_PAR = ((DIGITS - 1) % 2) == 1;

  cd_state_e        state, state_next;
  logic [CNT_W-1:0] cnt;
  logic             mode;
  logic             err;

  logic             accept;
  logic             first;
  logic             mode_cur;
  logic             is_check;
  logic             dbl;
  logic             bad;
  logic [3:0]       contrib;
  logic             frame_done;
  logic             err_next;
  logic [3:0]       acc_next;
  logic [3:0]       gen_digit;

  assign accept   = in_valid && (state != DONE);
  assign first    = (state == IDLE);
  assign mode_cur = first ? in_mode : mode;
  assign is_check = (cnt == LEN_GEN);
  assign dbl      = !is_check && (cnt[0] == DBL_PAR);
  assign bad      = (in_num > 4'd9);

  always_comb begin
    contrib = in_num;
    if (bad)
      contrib = 4'd0;
    else if (dbl)
      contrib = luhn_double(in_num);
  end

  assign frame_done = accept &&
                      ((cnt + CNT_W'(1)) == ((mode_cur == CD_VER) ? LEN_VER : LEN_GEN));
  assign err_next   = (first ? 1'b0 : err) | bad;
  assign gen_digit  = (acc_next == 4'd0) ? 4'd0 : 4'(4'd10 - acc_next);

  checkdigit_mod10_acc u_acc (
    .clk      (clk),
    .rst      (rst),
    .clear    (first && accept),
    .add_en   (accept),
    .add      (contrib),
    .acc_next (acc_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b1;
    case (state)
      IDLE: if (accept) state_next = ACC;
      ACC:  if (frame_done) state_next = DONE;
      DONE: begin
        in_ready   = 1'b0;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      mode <= CD_GEN;
      err  <= 1'b0;
    end else if (accept) begin
      cnt <= frame_done ? '0 : cnt + CNT_W'(1);
      err <= err_next;
      if (first) mode <= in_mode;
    end
  end

  // Results are captured from the post-add sum on the completing digit, so
  // they appear registered alongside out_valid and are zero otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out       <= 4'd0;
      out_pass  <= 1'b0;
      out_err   <= 1'b0;
    end else begin
      out_valid <= frame_done;
      out       <= (frame_done && mode_cur == CD_GEN && !err_next) ? gen_digit : 4'd0;
      out_pass  <= frame_done && mode_cur == CD_VER && !err_next && (acc_next == 4'd0);
      out_err   <= frame_done && err_next;
    end
  end

endmodule
